mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its write-back address, store data, execution result and PC. It performs byte/half/word loads and stores on a req/ack data-memory port, stalls the upstream stages while an access is outstanding, and registers the MEM/WB values for the write-back stage.

---
 rtl/mem_pkg.sv | 14 +
 rtl/load_store_align.sv | 44 ++++
 rtl/mem_stage.sv | 160 ++++++++++++++++
 tb/tb_mem_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM state and alignment helper for mem_stage
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic {IDLE, WAIT} state_t;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == SZ_H) && addr[0]) || ((size == SZ_W) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - combinational store lane steering and load lane extraction/extension
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wstrb = 4'hF;
    wdata = st_data;
    case (size)
      SZ_B: begin
        wstrb = 4'b0001 << addr;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        wstrb = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = rdata[{addr, 3'b000} +: 8];
    ld_half = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    ld_data = is_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = is_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory-access stage with req/ack data port, stall, timeout and MEM/WB register
// Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  in_regWAddr,
  input  logic [31:0] in_regRData2,
  input  logic [31:0] in_result,
  input  logic [31:0] in_pc,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_mem_size,
  input  logic        in_mem_unsigned,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        bus_err,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign_fault,
  output logic [31:0] fault_addr,
`endif
  output logic [4:0]  wb_regWAddr,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [31:0]   lat_addr, lat_data, lat_pc;
  logic [4:0]    lat_rd;
  logic [1:0]    lat_size;
  logic          lat_unsigned, lat_we;

  logic          in_wait, mem_op, misal, start, timeout_hit;
  logic [31:0]   cur_addr, cur_data, cur_pc, ld_data, al_wdata;
  logic [4:0]    cur_rd;
  logic [1:0]    cur_size;
  logic          cur_unsigned, cur_we;
  logic [3:0]    al_wstrb;

  assign in_wait = (state == WAIT);
  assign mem_op  = in_mem_read | in_mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misal   = misaligned(in_mem_size, in_result[1:0]);
`else
  assign misal   = 1'b0;
`endif
  assign start   = !in_wait && mem_op && !flush && !misal;

  // In WAIT everything the bus and completion see comes from the latches, so upstream changes cannot leak in.
  assign cur_addr     = in_wait ? lat_addr     : in_result;
  assign cur_data     = in_wait ? lat_data     : in_regRData2;
  assign cur_pc       = in_wait ? lat_pc       : in_pc;
  assign cur_rd       = in_wait ? lat_rd       : in_regWAddr;
  assign cur_size     = in_wait ? lat_size     : in_mem_size;
  assign cur_unsigned = in_wait ? lat_unsigned : in_mem_unsigned;
  assign cur_we       = in_wait ? lat_we       : in_mem_write;

  load_store_align u_align (
    .addr        (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_unsigned),
    .st_data     (cur_data),
    .rdata       (dmem_rdata),
    .wstrb       (al_wstrb),
    .wdata       (al_wdata),
    .ld_data     (ld_data)
  );

  assign dmem_req    = in_wait | start;
  assign dmem_we     = dmem_req & cur_we;
  assign dmem_addr   = {cur_addr[31:2], 2'b00};
  assign dmem_wstrb  = dmem_we ? al_wstrb : 4'h0;
  assign dmem_wdata  = al_wdata;
  assign mem_stall   = dmem_req & !dmem_ack;
  assign cnt_next    = cnt + CW'(1);
  assign timeout_hit = in_wait && !dmem_ack && (cnt_next == CW'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_pc       <= '0;
      lat_rd       <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_we       <= 1'b0;
      bus_err      <= 1'b0;
      wb_regWAddr  <= '0;
      wb_data      <= '0;
      wb_pc        <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
      fault_addr     <= '0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_fault <= 1'b0;
`endif
      if (!in_wait && (flush || (mem_op && !dmem_req))) begin
        wb_regWAddr <= '0;
        wb_data     <= '0;
        wb_pc       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (!flush) begin
          misalign_fault <= 1'b1;
          fault_addr     <= in_result;
        end
`endif
      end else if (!in_wait && !mem_op) begin
        wb_regWAddr <= in_regWAddr;
        wb_data     <= in_result;
        wb_pc       <= in_pc;
      end else if (dmem_ack) begin
        wb_regWAddr <= cur_we ? 5'd0 : cur_rd;
        wb_data     <= cur_we ? cur_addr : ld_data;
        wb_pc       <= cur_pc;
        state       <= IDLE;
      end else begin
        // Stalled or abandoned: bubble so the held instruction writes back only once.
        wb_regWAddr <= '0;
        wb_data     <= '0;
        wb_pc       <= '0;
        if (!in_wait) begin
          lat_addr     <= in_result;
          lat_data     <= in_regRData2;
          lat_pc       <= in_pc;
          lat_rd       <= in_regWAddr;
          lat_size     <= in_mem_size;
          lat_unsigned <= in_mem_unsigned;
          lat_we       <= in_mem_write;
          cnt          <= '0;
          state        <= WAIT;
        end else if (timeout_hit) begin
          bus_err <= 1'b1;
          state   <= IDLE;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (TIMEOUT = 4; honours MEM_MISALIGN_TRAP_EN)
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  in_regWAddr;
  logic [31:0] in_regRData2, in_result, in_pc;
  logic        in_mem_read, in_mem_write, in_mem_unsigned, flush;
  logic [1:0]  in_mem_size;
  logic        dmem_req, dmem_we, dmem_ack, mem_stall, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [4:0]  wb_regWAddr;
  logic [31:0] wb_data, wb_pc;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault;
  logic [31:0] fault_addr;
`endif

  int checks = 0;
  int failures = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .in_regWAddr(in_regWAddr), .in_regRData2(in_regRData2), .in_result(in_result), .in_pc(in_pc),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_size(in_mem_size),
    .in_mem_unsigned(in_mem_unsigned), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .bus_err(bus_err),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_fault(misalign_fault), .fault_addr(fault_addr),
`endif
    .wb_regWAddr(wb_regWAddr), .wb_data(wb_data), .wb_pc(wb_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd_en, input logic wr_en, input logic [1:0] sz, input logic uns,
                        input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [31:0] pc);
    in_mem_read     = rd_en;
    in_mem_write    = wr_en;
    in_mem_size     = sz;
    in_mem_unsigned = uns;
    in_regWAddr     = rd;
    in_result       = addr;
    in_regRData2    = sdata;
    in_pc           = pc;
  endtask

  task automatic clear_op;
    set_op(1'b0, 1'b0, SZ_B, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    clear_op;
    #12;
    check("rst_wb_rd", {27'b0, wb_regWAddr}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_pc", wb_pc, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    reset = 1'b0;
    tick;

    // zero-wait load word
    set_op(1'b1, 1'b0, SZ_W, 1'b0, 5'd5, 32'h100, 32'h0, 32'h40);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_req", {31'b0, dmem_req}, 32'h1);
    check("lw_stall", {31'b0, mem_stall}, 32'h0);
    check("lw_addr", dmem_addr, 32'h100);
    tick;
    check("lw_data", wb_data, 32'hDEADBEEF);
    check("lw_rd", {27'b0, wb_regWAddr}, 32'd5);
    check("lw_pc", wb_pc, 32'h40);

    // byte / half loads with sign handling
    set_op(1'b1, 1'b0, SZ_B, 1'b0, 5'd4, 32'h103, 32'h0, 32'h44);
    dmem_rdata = 32'h80FF0000;
    tick;
    check("lb_signed", wb_data, 32'hFFFFFF80);
    in_mem_unsigned = 1'b1;
    tick;
    check("lbu", wb_data, 32'h00000080);
    set_op(1'b1, 1'b0, SZ_H, 1'b0, 5'd4, 32'h102, 32'h0, 32'h48);
    tick;
    check("lh_signed", wb_data, 32'hFFFF80FF);

    // non-memory pass-through
    set_op(1'b0, 1'b0, SZ_W, 1'b0, 5'd7, 32'h12345678, 32'h0, 32'h4C);
    dmem_ack = 1'b0;
    #1;
    check("alu_req", {31'b0, dmem_req}, 32'h0);
    tick;
    check("alu_rd", {27'b0, wb_regWAddr}, 32'd7);
    check("alu_data", wb_data, 32'h12345678);
    check("alu_pc", wb_pc, 32'h4C);

    // word load at 0x101
    set_op(1'b1, 1'b0, SZ_W, 1'b0, 5'd5, 32'h101, 32'h0, 32'hE0);
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    check("mis_req", {31'b0, dmem_req}, 32'h0);
    tick;
    check("mis_fault", {31'b0, misalign_fault}, 32'h1);
    check("mis_addr", fault_addr, 32'h101);
    check("mis_wb_rd", {27'b0, wb_regWAddr}, 32'h0);
    clear_op;
    tick;
    check("mis_pulse", {31'b0, misalign_fault}, 32'h0);
`else
    dmem_ack = 1'b1;
    dmem_rdata = 32'h01020304;
    #1;
    check("unal_addr", dmem_addr, 32'h100);
    tick;
    check("unal_data", wb_data, 32'h01020304);
    dmem_ack = 1'b0;
    clear_op;
    tick;
`endif

    // store half with ack three cycles late; inputs garbled during WAIT
    set_op(1'b0, 1'b1, SZ_H, 1'b0, 5'd9, 32'h202, 32'h1234, 32'h90);
    dmem_ack = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (mem_stall) stall_cnt++;
      check($sformatf("sh_we_%0d", i), {31'b0, dmem_we}, 32'h1);
      check($sformatf("sh_addr_%0d", i), dmem_addr, 32'h200);
      check($sformatf("sh_wstrb_%0d", i), {28'b0, dmem_wstrb}, 32'hC);
      check($sformatf("sh_wdata_%0d", i), dmem_wdata, 32'h12341234);
      tick;
      if (i == 0) begin
        check("sh_bubble", {27'b0, wb_regWAddr}, 32'h0);
        in_result = 32'h55;
        in_regRData2 = 32'hFFFFFFFF;
        in_mem_size = SZ_W;
      end
    end
    dmem_ack = 1'b1;
    #1;
    if (mem_stall) stall_cnt++;
    check("sh_ack_stall", {31'b0, mem_stall}, 32'h0);
    tick;
    dmem_ack = 1'b0;
    clear_op;
    check("sh_stall_cycles", stall_cnt, 32'd3);
    check("sh_wb_rd", {27'b0, wb_regWAddr}, 32'h0);
    check("sh_wb_pc", wb_pc, 32'h90);

    // timeout: no ack, TIMEOUT = 4
    set_op(1'b1, 1'b0, SZ_W, 1'b0, 5'd3, 32'h300, 32'h0, 32'hA0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("to_req_%0d", i), {31'b0, dmem_req}, 32'h1);
      check($sformatf("to_err_%0d", i), {31'b0, bus_err}, 32'h0);
      tick;
    end
    check("to_err_pulse", {31'b0, bus_err}, 32'h1);
    check("to_wb_rd", {27'b0, wb_regWAddr}, 32'h0);
    clear_op;
    #1;
    check("to_idle", {31'b0, dmem_req}, 32'h0);
    tick;
    check("to_err_single", {31'b0, bus_err}, 32'h0);

    // flush during WAIT is ignored
    set_op(1'b1, 1'b0, SZ_B, 1'b1, 5'd6, 32'h101, 32'h0, 32'h80);
    tick;
    flush = 1'b1;
    #1;
    check("fw_req", {31'b0, dmem_req}, 32'h1);
    tick;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h0000AB00;
    #1;
    check("fw_stall", {31'b0, mem_stall}, 32'h0);
    tick;
    flush = 1'b0;
    dmem_ack = 1'b0;
    clear_op;
    check("fw_data", wb_data, 32'h000000AB);
    check("fw_rd", {27'b0, wb_regWAddr}, 32'd6);
    check("fw_pc", wb_pc, 32'h80);

    // flush in IDLE suppresses the access
    set_op(1'b1, 1'b0, SZ_W, 1'b0, 5'd8, 32'h400, 32'h0, 32'hC0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'h11111111;
    flush = 1'b1;
    #1;
    check("fi_req", {31'b0, dmem_req}, 32'h0);
    tick;
    flush = 1'b0;
    check("fi_rd", {27'b0, wb_regWAddr}, 32'h0);
    check("fi_data", wb_data, 32'h0);
    check("fi_pc", wb_pc, 32'h0);

    // byte and word stores, zero wait
    set_op(1'b0, 1'b1, SZ_B, 1'b0, 5'd0, 32'h201, 32'h000000A5, 32'hD0);
    #1;
    check("sb_wstrb", {28'b0, dmem_wstrb}, 32'h2);
    check("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    tick;
    set_op(1'b0, 1'b1, SZ_W, 1'b0, 5'd0, 32'h204, 32'hCAFEF00D, 32'hD4);
    #1;
    check("sw_wstrb", {28'b0, dmem_wstrb}, 32'hF);
    check("sw_wdata", dmem_wdata, 32'hCAFEF00D);
    tick;

    // asynchronous reset while in WAIT
    set_op(1'b1, 1'b0, SZ_W, 1'b0, 5'd2, 32'h500, 32'h0, 32'hF0);
    dmem_ack = 1'b0;
    tick;
    #2;
    reset = 1'b1;
    clear_op;
    #1;
    check("rw_req", {31'b0, dmem_req}, 32'h0);
    reset = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
